muldiv_sched: RTL

Sequencer that drives the shared multi-cycle multiplier and iterative divider from the execute stage. It latches operands and start/sign controls, and holds the pipeline stalled until the selected unit reports ready. It then forms the 64-bit HI/LO write value, including MADD/MSUB accumulation. It sits between the E-stage decode signals and the mul/div/hilo instances, and replaces the ad-hoc start/ready logic inside the ALU.

---
 rtl/muldiv_sched_pkg.sv | 36 +++
 rtl/md_acc.sv | 23 ++
 rtl/muldiv_sched.sv | 121 ++++++++++++
 3 files changed

// File: rtl/muldiv_sched_pkg.sv
// Shared mul/div op encoding and decode helpers used by the E-stage
// mul/div sequencer and its accumulate datapath.
package muldiv_sched_pkg;

    typedef enum logic [3:0] {
        MD_NONE  = 4'd0,
        MD_MULT  = 4'd1,
        MD_MULTU = 4'd2,
        MD_DIV   = 4'd3,
        MD_DIVU  = 4'd4,
        MD_MUL   = 4'd5,
        MD_MADD  = 4'd6,
        MD_MADDU = 4'd7,
        MD_MSUB  = 4'd8,
        MD_MSUBU = 4'd9
    } md_op_t;

    function automatic logic is_div(md_op_t op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic logic is_signed(md_op_t op);
        return (op == MD_MULT) || (op == MD_MUL) || (op == MD_MADD) ||
               (op == MD_MSUB) || (op == MD_DIV);
    endfunction

    function automatic logic is_acc(md_op_t op);
        return (op == MD_MADD) || (op == MD_MADDU) ||
               (op == MD_MSUB) || (op == MD_MSUBU);
    endfunction

    function automatic logic is_sub(md_op_t op);
        return (op == MD_MSUB) || (op == MD_MSUBU);
    endfunction

endpackage

// File: rtl/md_acc.sv
// HI/LO write-value former: plain pass-through of the unit result, or
// accumulate into the current HI:LO for MADD/MSUB (wraps mod 2^64).
module md_acc
    import muldiv_sched_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [63:0] hilo_cur,
    input  logic [63:0] result,
    output logic [63:0] wdata
);

    md_op_t op_e;
    assign op_e = md_op_t'(op);

    always_comb begin
        wdata = result;
        if (is_acc(op_e)) begin
            if (is_sub(op_e)) wdata = hilo_cur - result;
            else              wdata = hilo_cur + result;
        end
    end

endmodule

// File: rtl/muldiv_sched.sv
// E-stage sequencer for the shared multiplier and divider: latches the op,
// runs the selected unit until ready, then issues the HI/LO write.
module muldiv_sched
    import muldiv_sched_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        op_valid,
    input  logic [3:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic [63:0] hilo_cur,
    input  logic        stall_ext,
    input  logic        flush,
    input  logic        flush_exception,
    input  logic        mul_ready,
    input  logic [63:0] mul_result,
    input  logic        div_ready,
    input  logic [63:0] div_result,
    output logic        mul_start,
    output logic        mul_sign,
    output logic        div_start,
    output logic        div_sign,
    output logic [31:0] op_a,
    output logic [31:0] op_b,
    output logic        unit_flush,
    output logic        md_stall,
    output logic        hilo_we,
    output logic [63:0] hilo_wdata,
    output logic [31:0] lo_result,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MUL_BUSY = 2'd1,
        DIV_BUSY = 2'd2,
        DONE     = 2'd3
    } state_t;

    state_t      state;
    md_op_t      op_in;
    md_op_t      op_q;
    logic [63:0] result_q;

    assign op_in = md_op_t'(op);

    // Unit handshake: start/sign stay high for the whole busy state; the unit
    // raises ready for the cycle its result is valid, and we capture it then.
    // A flush in the same cycle as ready wins and the result is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            op_q      <= MD_NONE;
            op_a      <= '0;
            op_b      <= '0;
            result_q  <= '0;
            mul_start <= 1'b0;
            mul_sign  <= 1'b0;
            div_start <= 1'b0;
            div_sign  <= 1'b0;
        end else if (flush) begin
            state     <= IDLE;
            mul_start <= 1'b0;
            mul_sign  <= 1'b0;
            div_start <= 1'b0;
            div_sign  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (op_valid && (op_in != MD_NONE)) begin
                        op_q      <= op_in;
                        op_a      <= src_a;
                        op_b      <= src_b;
                        state     <= is_div(op_in) ? DIV_BUSY : MUL_BUSY;
                        mul_start <= !is_div(op_in);
                        mul_sign  <= !is_div(op_in) && is_signed(op_in);
                        div_start <= is_div(op_in);
                        div_sign  <= is_div(op_in) && is_signed(op_in);
                    end
                end
                MUL_BUSY: begin
                    if (mul_ready) begin
                        result_q  <= mul_result;
                        state     <= DONE;
                        mul_start <= 1'b0;
                        mul_sign  <= 1'b0;
                    end
                end
                DIV_BUSY: begin
                    if (div_ready) begin
                        result_q  <= div_result;
                        state     <= DONE;
                        div_start <= 1'b0;
                        div_sign  <= 1'b0;
                    end
                end
                DONE: begin
                    if (!stall_ext) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // The write fires only in the DONE cycle that actually leaves E.
    assign hilo_we    = !rst && !flush && (state == DONE) && !stall_ext &&
                        !flush_exception && (op_q != MD_MUL);
    assign md_stall   = !rst && op_valid && (op_in != MD_NONE) && (state != DONE);
    assign unit_flush = flush && !rst;
    assign lo_result  = (state == DONE) ? result_q[31:0] : 32'd0;
    assign dbg_state  = state;

    md_acc u_acc (
        .op       (op_q),
        .hilo_cur (hilo_cur),
        .result   (result_q),
        .wdata    (hilo_wdata)
    );

endmodule
